// File: rtl/arbitro_compuertas_pkg.sv
// Shared definitions for the gate-unit arbiter: opcodes, FSM encoding, opcode check.
package compuertas_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;

    // IDLE: output register empty; FULL: holding a result for the consumer.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/arbitro_compuertas_if.sv
// Request/response bundle between client blocks and the shared gate-unit arbiter.
interface arbitro_compuertas_if
    import compuertas_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0][OP_W-1:0]      req_op;
    logic [NUM_REQ-1:0][WIDTH-1:0]     req_a;
    logic [NUM_REQ-1:0][WIDTH-1:0]     req_b;
    logic                              resp_valid;
    logic                              resp_ready;
    logic [WIDTH-1:0]                  resp_data;
    logic [ID_W-1:0]                   resp_id;
    logic                              resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_err
    );

endinterface

// File: rtl/arbitro_compuertas_unidad_logica.sv
// Combinational WIDTH-bit gate unit; illegal opcodes yield zero with err set.
module unidad_logica
    import compuertas_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = !op_legal(op);
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/arbitro_compuertas.sv
// Round-robin arbiter sharing one gate unit among NUM_REQ clients, with a
// one-deep registered, id-tagged response stage.
module arbitro_compuertas
    import compuertas_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    arbitro_compuertas_if.slave  bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic             resp_err_q, resp_err_d;

    logic             can_accept;
    logic             accept;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_idx;
    logic [OP_W-1:0]  sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_err;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    assign sel_op = bus.req_op[gnt_idx];
    assign sel_a  = bus.req_a[gnt_idx];
    assign sel_b  = bus.req_b[gnt_idx];

    unidad_logica #(.WIDTH(WIDTH)) u_unidad (
        .op  (sel_op),
        .a   (sel_a),
        .b   (sel_b),
        .y   (alu_y),
        .err (alu_err)
    );

    // A retiring response frees the register in the same cycle, so FULL can
    // still accept and sustain one result per cycle.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_FULL && bus.resp_ready);
    assign accept     = can_accept && gnt_found && !rst;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)               state_d = ST_FULL;
                else if (bus.resp_ready)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            resp_data_d = alu_y;
            resp_id_d   = gnt_idx;
            resp_err_d  = alu_err;
            rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign bus.resp_valid = (state_q == ST_FULL);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_arbitro_compuertas.sv
// Scoreboard bench: a behavioural arbiter model predicts grants and results,
// a separate monitor checks every presented response against the queue.
module tb_arbitro_compuertas;
    import compuertas_pkg::*;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct { logic [2:0] op; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } txn_t;
    typedef struct { logic [WIDTH-1:0] d; logic [ID_W-1:0] id; logic err; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arbitro_compuertas_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();
    arbitro_compuertas #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    exp_t             sb[$];
    txn_t             dq[NUM_REQ][$];
    txn_t             cur[NUM_REQ];
    logic [NUM_REQ-1:0] vld       = '0;
    logic [NUM_REQ-1:0] done_mask = '0;
    bit   rnd_en  = 0;
    bit   rr_rand = 0;
    logic rr_fix  = 1'b1;
    int   m_ptr   = 0;
    bit   m_full  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t gate_ref(input txn_t t, input int id);
        exp_t e;
        e.id  = ID_W'(id);
        e.err = 1'b0;
        case (t.op)
            3'd0: e.d = t.a & t.b;
            3'd1: e.d = t.a | t.b;
            3'd2: e.d = ~t.a;
            3'd3: e.d = ~(t.a & t.b);
            3'd4: e.d = ~(t.a | t.b);
            3'd5: e.d = t.a ^ t.b;
            default: begin e.d = '0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // Reference model: output slot occupancy, round-robin pointer, predictions.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
            m_full    = 0;
            m_ptr     = 0;
            done_mask = '0;
            sb.delete();
        end else begin
            int g;
            int idx;
            logic [NUM_REQ-1:0] er;
            g  = -1;
            er = '0;
            chk("resp_valid", 32'(bus.resp_valid), 32'(m_full));
            if (!m_full || bus.resp_ready)
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && bus.req_valid[idx]) g = idx;
                end
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            done_mask = er;
            if (g >= 0) begin
                sb.push_back(gate_ref(cur[g], g));
                m_full = 1;
                m_ptr  = (g + 1) % NUM_REQ;
            end else if (bus.resp_ready) begin
                m_full = 0;
            end
        end
    end

    // Monitor: every presented response must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: response id %0d data %0h with nothing expected", bus.resp_id, bus.resp_data);
            end else begin
                chk("resp_data", 32'(bus.resp_data), 32'(sb[0].d));
                chk("resp_id",   32'(bus.resp_id),   32'(sb[0].id));
                chk("resp_err",  32'(bus.resp_err),  32'(sb[0].err));
                if (bus.resp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (done_mask[i]) vld[i] = 1'b0;
            if (!vld[i]) begin
                if (dq[i].size() > 0) begin
                    cur[i] = dq[i].pop_front();
                    vld[i] = 1'b1;
                end else if (rnd_en && $urandom_range(99) < 50) begin
                    cur[i].op = 3'($urandom_range(7));
                    cur[i].a  = 8'($urandom);
                    cur[i].b  = 8'($urandom);
                    vld[i]    = 1'b1;
                end
            end
            bus.req_op[i] = cur[i].op;
            bus.req_a[i]  = cur[i].a;
            bus.req_b[i]  = cur[i].b;
        end
        bus.req_valid  = vld;
        bus.resp_ready = rr_rand ? ($urandom_range(99) < 70) : rr_fix;
    endtask

    task automatic push(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        txn_t t;
        t.op = op; t.a = a; t.b = b;
        dq[r].push_back(t);
    endtask

    task automatic post_reset_chk(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.resp_data),  32'd0);
        chk({tag, "_id"},    32'(bus.resp_id),    32'd0);
        chk({tag, "_err"},   32'(bus.resp_err),   32'd0);
    endtask

    function automatic bit work_left();
        bit w;
        w = (vld != '0) || (sb.size() != 0);
        for (int i = 0; i < NUM_REQ; i++) if (dq[i].size() != 0) w = 1;
        return w;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NUM_REQ; i++) begin
            cur[i].op = '0; cur[i].a = '0; cur[i].b = '0;
        end
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        post_reset_chk("reset");

        push(1, 3'd0, 8'hF0, 8'h3C);
        repeat (4) step();

        for (int op = 0; op < 8; op++) push(0, 3'(op), 8'hA5, 8'h0F);
        repeat (12) step();

        for (int k = 0; k < 5; k++)
            for (int i = 0; i < NUM_REQ; i++) push(i, 3'($urandom_range(5)), 8'($urandom), 8'($urandom));
        repeat (25) step();

        rr_fix = 1'b0;
        push(2, 3'd5, 8'h5A, 8'hFF);
        push(2, 3'd1, 8'h12, 8'h40);
        repeat (6) step();
        rr_fix = 1'b1;
        repeat (6) step();

        push(2, 3'd3, 8'h77, 8'h0E);
        repeat (3) step();
        push(1, 3'd4, 8'h81, 8'h18);
        repeat (3) step();
        push(1, 3'd0, 8'hFF, 8'h0F);
        push(2, 3'd2, 8'h3C, 8'h00);
        repeat (5) step();

        rnd_en  = 1;
        rr_rand = 1;
        repeat (1500) step();

        rnd_en  = 0;
        rr_rand = 0;
        rr_fix  = 1'b0;
        push(0, 3'd1, 8'h0F, 8'hF0);
        repeat (4) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        post_reset_chk("midreset");

        rr_fix  = 1'b1;
        rnd_en  = 1;
        rr_rand = 1;
        repeat (500) step();

        rnd_en  = 0;
        rr_rand = 0;
        rr_fix  = 1'b1;
        n = 0;
        while (work_left() && n < 200) begin
            step();
            n++;
        end
        chk("drain_in_time", 32'(n < 200), 32'd1);
        chk("sb_empty_end",  32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
